// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, limits and saturation helper for the countdown timer
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    localparam int MAX_VALUE = 99;
    localparam int CNT_W     = 7;

    // Clamp an 8-bit intermediate to the two-digit display ceiling.
    function automatic logic [CNT_W-1:0] sat_max(input logic [CNT_W:0] v);
        if (v > (CNT_W+1)'(MAX_VALUE)) begin
            return CNT_W'(MAX_VALUE);
        end
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divide-by-DIV tick generator, holds its phase while disabled
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = i_en && (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - 0..99 seconds countdown with load, start, pause, bonus add and expiry flags
module countdown_timer
    import timer_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TICK_HZ    = 1,
    parameter int INIT_VALUE = 60
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_add,
    input  logic [CNT_W-1:0] i_add_value,
    output logic [31:0]      o_value,
    output logic             o_running,
    output logic             o_done,
    output logic             o_expired
);

    localparam int DIV = CLK_FREQ / TICK_HZ;

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             running_q;
    logic             done_q, done_d;
    logic             expired_q, expired_d;
    logic             tick;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] next_count;

    // Clearing throughout IDLE covers both load and the IDLE->RUN restart.
    tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (state_q == RUN),
        .i_clr (i_load || (state_q == IDLE)),
        .o_tick(tick)
    );

    // count is never 0 in RUN, so subtracting the tick cannot underflow.
    assign sum        = {1'b0, count_q} + (i_add ? {1'b0, i_add_value} : '0) - {{CNT_W{1'b0}}, tick};
    assign next_count = sat_max(sum);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        done_d    = 1'b0;
        expired_d = expired_q;
        if (i_load) begin
            count_d   = sat_max({1'b0, i_load_value});
            state_d   = IDLE;
            expired_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start && (count_q != '0)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    count_d = next_count;
                    if (next_count == '0) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        expired_d = 1'b1;
                    end else if (i_pause) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    count_d = next_count;
                    if (i_start) begin
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            count_q   <= CNT_W'(INIT_VALUE);
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            running_q <= (state_d == RUN);
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    assign o_value   = {{(32-CNT_W){1'b0}}, count_q};
    assign o_running = running_q;
    assign o_done    = done_q;
    assign o_expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed and randomized checks of countdown_timer against a behavioural model
module tb_countdown_timer;

    localparam int DIV  = 10;
    localparam int INIT = 60;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_load = 1'b0;
    logic [6:0]  i_load_value = '0;
    logic        i_start = 1'b0;
    logic        i_pause = 1'b0;
    logic        i_add = 1'b0;
    logic [6:0]  i_add_value = '0;
    logic [31:0] o_value;
    logic        o_running;
    logic        o_done;
    logic        o_expired;

    int checks = 0;
    int errors = 0;

    // Reference model: count, run/pause/expired flags, cycles elapsed in the current tick period.
    int m_count = INIT;
    int m_phase = 0;
    bit m_run   = 0;
    bit m_pause = 0;
    bit m_exp   = 0;
    bit m_done  = 0;

    countdown_timer #(
        .CLK_FREQ  (10),
        .TICK_HZ   (1),
        .INIT_VALUE(INIT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (i_load),
        .i_load_value(i_load_value),
        .i_start     (i_start),
        .i_pause     (i_pause),
        .i_add       (i_add),
        .i_add_value (i_add_value),
        .o_value     (o_value),
        .o_running   (o_running),
        .o_done      (o_done),
        .o_expired   (o_expired)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int nxt;
        bit tick;
        if (i_rst) begin
            m_count = INIT; m_phase = 0; m_run = 0; m_pause = 0; m_exp = 0; m_done = 0;
            return;
        end
        m_done = 0;
        tick = m_run && (m_phase == DIV - 1);
        if (m_run) m_phase = (m_phase + 1) % DIV;
        if (i_load) begin
            m_count = (i_load_value > 99) ? 99 : int'(i_load_value);
            m_run = 0; m_pause = 0; m_exp = 0; m_phase = 0;
        end else if (m_run || m_pause) begin
            nxt = m_count - int'(tick) + (i_add ? int'(i_add_value) : 0);
            if (nxt > 99) nxt = 99;
            m_count = nxt;
            if (m_run && nxt == 0) begin
                m_run = 0; m_exp = 1; m_done = 1;
            end else if (m_run && i_pause) begin
                m_run = 0; m_pause = 1;
            end else if (m_pause && i_start) begin
                m_run = 1; m_pause = 0;
            end
        end else if (!m_exp && i_start && m_count > 0) begin
            m_run = 1; m_phase = 0;
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        model_step();
        #1;
        check("model_value", int'(o_value), m_count);
        check("model_running", int'(o_running), int'(m_run));
        check("model_done", int'(o_done), int'(m_done));
        check("model_expired", int'(o_expired), int'(m_exp));
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse_start();
        i_start = 1; cyc(); i_start = 0;
    endtask

    task automatic do_load(input int v);
        i_load = 1; i_load_value = 7'(v); cyc(); i_load = 0;
    endtask

    task automatic do_add(input int v);
        i_add = 1; i_add_value = 7'(v); cyc(); i_add = 0;
    endtask

    task automatic wait_value(input int v, input int budget);
        int n = 0;
        while (int'(o_value) != v && n < budget) begin
            cyc();
            n++;
        end
        check("wait_value", int'(o_value), v);
    endtask

    initial begin
        // Reset and idle
        run(2);
        i_rst = 0;
        cyc();
        check("rst_value", int'(o_value), 60);
        check("rst_running", int'(o_running), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_expired", int'(o_expired), 0);
        run(30);
        check("idle_value", int'(o_value), 60);
        check("idle_running", int'(o_running), 0);

        // First decrement 11 edges after the edge the start was driven from
        pulse_start();
        run(9);
        check("pre_first_tick", int'(o_value), 60);
        cyc();
        check("first_tick", int'(o_value), 59);
        run(10);
        check("second_tick", int'(o_value), 58);

        // Expiry
        do_load(3);
        pulse_start();
        run(10);
        check("exp_2", int'(o_value), 2);
        run(10);
        check("exp_1", int'(o_value), 1);
        run(10);
        check("exp_0", int'(o_value), 0);
        check("exp_done", int'(o_done), 1);
        check("exp_expired", int'(o_expired), 1);
        check("exp_running", int'(o_running), 0);
        cyc();
        check("done_pulse_end", int'(o_done), 0);
        check("expired_sticky", int'(o_expired), 1);
        pulse_start();
        check("done_start_ignored", int'(o_value), 0);
        check("done_start_running", int'(o_running), 0);
        do_load(5);
        check("reload_expired", int'(o_expired), 0);
        check("reload_value", int'(o_value), 5);

        // Saturation on load and add
        do_load(120);
        check("load_sat", int'(o_value), 99);
        pulse_start();
        wait_value(97, 40);
        do_add(10);
        check("add_sat", int'(o_value), 99);
        check("add_running", int'(o_running), 1);

        // Pause four cycles into a period preserves the partial period
        do_load(50);
        pulse_start();
        run(3);
        i_pause = 1; cyc(); i_pause = 0;
        repeat (25) begin
            cyc();
            check("pause_hold", int'(o_value), 50);
        end
        check("pause_running", int'(o_running), 0);
        pulse_start();
        run(5);
        check("resume_pre", int'(o_value), 50);
        cyc();
        check("resume_tick", int'(o_value), 49);

        // Tick and add on count 1: no expiry
        do_load(2);
        pulse_start();
        wait_value(1, 20);
        run(9);
        do_add(5);
        check("tick_add_value", int'(o_value), 5);
        check("tick_add_done", int'(o_done), 0);
        check("tick_add_running", int'(o_running), 1);

        // Reset mid-RUN, then the prescaler restarts from 0
        do_load(42);
        pulse_start();
        run(3);
        check("mid_run_value", int'(o_value), 42);
        i_rst = 1; cyc(); i_rst = 0;
        check("mid_rst_value", int'(o_value), 60);
        check("mid_rst_running", int'(o_running), 0);
        check("mid_rst_done", int'(o_done), 0);
        pulse_start();
        run(9);
        check("post_rst_pre", int'(o_value), 60);
        cyc();
        check("post_rst_tick", int'(o_value), 59);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            i_rst   = ($urandom_range(0, 511) == 0);
            i_load  = ($urandom_range(0, 63) == 0);
            i_load_value = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 8)) : 7'($urandom_range(0, 127));
            i_start = ($urandom_range(0, 7) == 0);
            i_pause = ($urandom_range(0, 15) == 0);
            i_add   = ($urandom_range(0, 15) == 0);
            i_add_value = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 3));
            cyc();
        end
        i_rst = 0; i_load = 0; i_start = 0; i_pause = 0; i_add = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
